// File: rtl/chaotic_iter_ctrl.sv
// ============================================================================
//  Module      : chaotic_iter_ctrl
//  Description : Iteration sequencer for the 3-D chaotic equation datapath.
//                Issues one iteration at a time, discards warm-up states and
//                streams the remaining states out over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module chaotic_iter_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] y0,
  input  logic [DATA_WIDTH-1:0] z0,
  input  logic [CNT_WIDTH-1:0]  num_iter,
  input  logic [CNT_WIDTH-1:0]  num_skip,
  output logic                  eq_n_valid,
  output logic [DATA_WIDTH-1:0] eq_xn,
  output logic [DATA_WIDTH-1:0] eq_yn,
  output logic [DATA_WIDTH-1:0] eq_zn,
  input  logic                  eq_n1_valid,
  input  logic [DATA_WIDTH-1:0] eq_xn1,
  input  logic [DATA_WIDTH-1:0] eq_yn1,
  input  logic [DATA_WIDTH-1:0] eq_zn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  iter_cnt
);

  localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] c_ONE      = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_OUTPUT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_skip_left;
  logic [CNT_WIDTH-1:0]  r_out_left;
  logic [c_WAIT_W-1:0]   r_wait_cnt;

  assign busy = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_OUTPUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_skip_left <= '0;
      r_out_left  <= '0;
      r_wait_cnt  <= '0;
      eq_n_valid  <= 1'b0;
      eq_xn       <= '0;
      eq_yn       <= '0;
      eq_zn       <= '0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_z       <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      iter_cnt    <= '0;
    end else begin
      eq_n_valid <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        // Present-state registers are intentionally left untouched.
        r_state   <= S_IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              eq_xn       <= x0;
              eq_yn       <= y0;
              eq_zn       <= z0;
              r_skip_left <= num_skip;
              r_out_left  <= num_iter;
              iter_cnt    <= '0;
              timeout_err <= 1'b0;
              if (num_iter == '0) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state    <= S_ISSUE;
                eq_n_valid <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            r_state    <= S_WAIT;
            r_wait_cnt <= '0;
          end
          S_WAIT: begin
            if (eq_n1_valid) begin
              eq_xn <= eq_xn1;
              eq_yn <= eq_yn1;
              eq_zn <= eq_zn1;
              if (iter_cnt != '1) iter_cnt <= iter_cnt + c_ONE;
              if (r_skip_left != '0) begin
                r_skip_left <= r_skip_left - c_ONE;
                r_state     <= S_ISSUE;
                eq_n_valid  <= 1'b1;
              end else begin
                out_x     <= eq_xn1;
                out_y     <= eq_yn1;
                out_z     <= eq_zn1;
                out_valid <= 1'b1;
                out_last  <= (r_out_left == c_ONE);
                r_state   <= S_OUTPUT;
              end
            end else if (r_wait_cnt == c_WAIT_LAST) begin
              timeout_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end
          end
          S_OUTPUT: begin
            if (out_ready) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              r_out_left <= r_out_left - c_ONE;
              if (r_out_left == c_ONE) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state    <= S_ISSUE;
                eq_n_valid <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chaotic_iter_ctrl.sv
// ============================================================================
//  Module      : tb_chaotic_iter_ctrl
//  Description : Scoreboard bench for chaotic_iter_ctrl with a behavioural
//                datapath model and a queue of expected output states.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_chaotic_iter_ctrl;

  localparam int DW = 64;
  localparam int CW = 32;
  localparam int TO = 1023;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [DW-1:0] x0 = '0, y0 = '0, z0 = '0;
  logic [CW-1:0] num_iter = '0, num_skip = '0;
  logic          eq_n_valid;
  logic [DW-1:0] eq_xn, eq_yn, eq_zn;
  logic          eq_n1_valid = 1'b0;
  logic [DW-1:0] eq_xn1 = '0, eq_yn1 = '0, eq_zn1 = '0;
  logic          out_valid, out_ready = 1'b0, out_last, busy, done, timeout_err;
  logic [DW-1:0] out_x, out_y, out_z;
  logic [CW-1:0] iter_cnt;

  chaotic_iter_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .z0(z0), .num_iter(num_iter), .num_skip(num_skip),
    .eq_n_valid(eq_n_valid), .eq_xn(eq_xn), .eq_yn(eq_yn), .eq_zn(eq_zn),
    .eq_n1_valid(eq_n1_valid), .eq_xn1(eq_xn1), .eq_yn1(eq_yn1), .eq_zn1(eq_zn1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_last(out_last),
    .busy(busy), .done(done), .timeout_err(timeout_err), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] x, y, z;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0, n_tot = 0;
  int   issue_cnt = 0, done_cnt = 0;
  int   dp_lat = 20, dp_cnt = 0;
  bit   dp_silent = 0;
  int   ready_mode = 1;      // 0: held low, 1: held high, 2: random
  logic [3*DW-1:0] dp_in = '0;
  int   run_ib, run_db, run_n;

  // Stand-in for the forward-Euler datapath: any fixed deterministic map will do.
  function automatic logic [3*DW-1:0] step(input logic [3*DW-1:0] s);
    logic [DW-1:0] x, y, z;
    x = s[3*DW-1:2*DW];
    y = s[2*DW-1:DW];
    z = s[DW-1:0];
    return {x + ((y ^ (x >> 3)) * 64'd3),
            y * 64'd5 + z + 64'd1,
            {z[DW-2:0], z[DW-1]} ^ (x + y)};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Datapath model plus issue/done event counters.
  initial forever begin
    @(negedge clk);
    eq_n1_valid = 1'b0;
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0 && !dp_silent) begin
        eq_n1_valid = 1'b1;
        {eq_xn1, eq_yn1, eq_zn1} = step(dp_in);
      end
    end
    if (eq_n_valid) begin
      issue_cnt++;
      dp_in  = {eq_xn, eq_yn, eq_zn};
      dp_cnt = dp_lat;
    end
    if (done) done_cnt++;
  end

  // Output monitor: drives out_ready and pops the scoreboard on each handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_x", out_x, e.x);
        check("out_y", out_y, e.y);
        check("out_z", out_z, e.z);
        check("out_last", {63'd0, out_last}, {63'd0, e.last});
      end
    end
  end

  task automatic pulse_start(input logic [DW-1:0] x, y, z, input int skip, iter);
    @(negedge clk);
    x0 = x; y0 = y; z0 = z;
    num_skip = CW'(skip);
    num_iter = CW'(iter);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference: iterate the map skip+iter times, keep the last iter states.
  task automatic start_run(input logic [DW-1:0] x, y, z, input int skip, iter);
    logic [3*DW-1:0] s;
    exp_t e;
    s = {x, y, z};
    for (int i = 1; i <= skip + iter; i++) begin
      s = step(s);
      if (i > skip) begin
        e.x = s[3*DW-1:2*DW]; e.y = s[2*DW-1:DW]; e.z = s[DW-1:0];
        e.last = (i == skip + iter);
        sb.push_back(e);
      end
    end
    run_ib = issue_cnt;
    run_db = done_cnt;
    run_n  = skip + iter;
    pulse_start(x, y, z, skip, iter);
  endtask

  task automatic finish_run(input string tag);
    int n;
    n = 0;
    while (done_cnt == run_db && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != run_db), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - run_db), 64'd1);
    check({tag, "_issues"}, 64'(issue_cnt - run_ib), 64'(run_n));
    check({tag, "_iter_cnt"}, 64'(iter_cnt), 64'(run_n));
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] cap_x, cap_y, cap_z;
    int ib, db, n;
    bit stable;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ctrl", 64'({eq_n_valid, out_valid, out_last, busy, done, timeout_err}), 64'd0);
    check("rst_state", eq_xn | eq_yn | eq_zn, 64'd0);
    check("rst_out", out_x | out_y | out_z, 64'd0);
    check("rst_iter_cnt", 64'(iter_cnt), 64'd0);

    // Directed golden run from x=1.0.
    dp_lat = 20;
    start_run(64'h3FF0000000000000, 64'd0, 64'd0, 0, 3);
    finish_run("basic");

    // Warm-up iterations are discarded.
    start_run(64'h3FF0000000000000, 64'd0, 64'd0, 5, 2);
    finish_run("skip");

    // Back-pressure: output held, nothing new issued, mid-run start ignored.
    ready_mode = 0;
    dp_lat = 4;
    start_run(64'h0123456789ABCDEF, 64'h1111, 64'h2222, 1, 2);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid", 64'(out_valid), 64'd1);
    cap_x = out_x; cap_y = out_y; cap_z = out_z;
    ib = issue_cnt;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        x0 = 64'hDEAD; num_iter = 32'd9; start = 1'b1;
      end
      if (i == 11) start = 1'b0;
      @(negedge clk);
      if (!out_valid || out_x !== cap_x || out_y !== cap_y || out_z !== cap_z) stable = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    check("stall_no_issue", 64'(issue_cnt - ib), 64'd0);
    ready_mode = 2;
    finish_run("stall");

    // num_iter == 0: immediate done, no issue.
    ib = issue_cnt;
    pulse_start(64'h5, 64'h6, 64'h7, 3, 0);
    check("zero_done", 64'(done), 64'd1);
    @(negedge clk);
    check("zero_done_once", 64'(done), 64'd0);
    check("zero_no_issue", 64'(issue_cnt - ib), 64'd0);

    // Timeout: datapath never answers.
    dp_silent = 1;
    db = done_cnt;
    pulse_start(64'h9, 64'h8, 64'h7, 0, 1);
    check("to_issue", 64'(eq_n_valid), 64'd1);
    n = 0;
    while (!timeout_err && n < 2000) begin
      @(negedge clk);
      n++;
    end
    // Issue cycle, then TIMEOUT cycles of waiting, then the sticky flag.
    check("to_cycles", 64'(n), 64'(TO + 1));
    check("to_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("to_no_done", 64'(done_cnt - db), 64'd0);
    dp_silent = 0;
    repeat (30) @(negedge clk);

    // Abort mid-WAIT; the late datapath result must be ignored.
    dp_lat = 20;
    pulse_start(64'hAAAA, 64'hBBBB, 64'hCCCC, 0, 2);
    check("abort_to_clear", 64'(timeout_err), 64'd0);
    repeat (5) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    repeat (30) @(negedge clk);
    check("abort_state_kept", eq_xn, 64'hAAAA);
    check("abort_idle", 64'({busy, out_valid}), 64'd0);
    check("abort_iter_cnt", 64'(iter_cnt), 64'd0);

    // Asynchronous reset mid-WAIT.
    pulse_start(64'h1234, 64'h5678, 64'h9ABC, 0, 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", 64'({eq_n_valid, out_valid, out_last, busy, done, timeout_err}), 64'd0);
    check("rst_mid_state", eq_xn | eq_yn | eq_zn | 64'(iter_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    start_run(64'h3FF0000000000000, 64'd0, 64'd0, 1, 2);
    finish_run("post_rst");

    // Randomised runs.
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      dp_lat = $urandom_range(1, 10);
      start_run({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 4), $urandom_range(1, 5));
      finish_run($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
